// File: rtl/tb_match_monitor.sv
// Result collector for block-level benches: scores tb_match over framed test windows,
// buffers per-window summaries in a small FIFO and classifies DUT-reset probes.
module tb_match_monitor #(
  parameter int CNT_W      = 16,
  parameter int ID_W       = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tb_match,
  input  logic             dut_rst,
  input  logic             async_mode,
  input  logic             win_enable,
  input  logic [ID_W-1:0]  win_id,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ID_W-1:0]  res_id,
  output logic [CNT_W-1:0] res_samples,
  output logic [CNT_W-1:0] res_mismatch,
  output logic [CNT_W-1:0] res_first,
  output logic             hint_valid,
  output logic [1:0]       hint_code,
  output logic [CNT_W-1:0] tot_windows,
  output logic [CNT_W-1:0] tot_fail,
  output logic             overflow,
  output logic             all_pass
);

  localparam int              PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [CNT_W-1:0] samples;
    logic [CNT_W-1:0] mismatch;
    logic [CNT_W-1:0] first;
  } summary_t;

  typedef enum logic {W_IDLE, W_ACTIVE} win_state_t;

  typedef enum logic [1:0] {
    HINT_PASS       = 2'd0,
    HINT_NO_RESET   = 2'd1,
    HINT_WRONG_SYNC = 2'd2
  } hint_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Window FSM
  win_state_t       state_q, state_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [CNT_W-1:0] samples_q, samples_d;
  logic [CNT_W-1:0] mism_q, mism_d;
  logic [CNT_W-1:0] first_q, first_d;
  logic             close_win;
  logic             mism_now;

  assign mism_now = !tb_match;

  // NOTE: every signal driven here gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    samples_d = samples_q;
    mism_d    = mism_q;
    first_d   = first_q;
    close_win = (state_q == W_ACTIVE) && (!win_enable || (win_id != id_q));
    if (win_enable && ((state_q == W_IDLE) || close_win)) begin
      state_d   = W_ACTIVE;
      id_d      = win_id;
      samples_d = CNT_W'(1);
      mism_d    = mism_now ? CNT_W'(1) : '0;
      first_d   = mism_now ? '0 : CNT_MAX;
    end else if (win_enable) begin
      samples_d = sat_inc(samples_q);
      if (mism_now) begin
        mism_d = sat_inc(mism_q);
        if (first_q == CNT_MAX) first_d = samples_q;
      end
    end else begin
      state_d = W_IDLE;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= W_IDLE;
      id_q      <= '0;
      samples_q <= '0;
      mism_q    <= '0;
      first_q   <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      samples_q <= samples_d;
      mism_q    <= mism_d;
      first_q   <= first_d;
    end
  end

  // Summary FIFO: extra pointer bit distinguishes full from empty
  summary_t         mem [FIFO_DEPTH];
  summary_t         head;
  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic             empty, full, push, pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop   = res_valid && res_ready;
  assign push  = close_win && (!full || pop);

  // NOTE: the storage array is not reset; only the pointers are, and the outputs
  // are masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= '{id: id_q, samples: samples_q,
                                          mismatch: mism_q, first: first_q};
  end

  assign head         = mem[rd_ptr[PTR_W-1:0]];
  assign res_valid    = !empty;
  assign res_id       = res_valid ? head.id       : '0;
  assign res_samples  = res_valid ? head.samples  : '0;
  assign res_mismatch = res_valid ? head.mismatch : '0;
  assign res_first    = res_valid ? head.first    : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      tot_windows <= '0;
      tot_fail    <= '0;
      overflow    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      if (close_win) begin
        tot_windows <= sat_inc(tot_windows);
        if (mism_q != '0) tot_fail <= sat_inc(tot_fail);
        if (!push) overflow <= 1'b1;
      end
    end
  end

  // Reset probe: detect edge captures arfail, the following edge captures srfail
  logic  dut_rst_q, data_fail_q, data_fail_hold, ar_fail_q, probe_q, hint_bad;
  logic  rst_rise;
  hint_t probe_code;

  assign rst_rise = dut_rst && !dut_rst_q;

  always_comb begin
    probe_code = HINT_PASS;
    if (!tb_match)
      probe_code = HINT_NO_RESET;
    else if (ar_fail_q && (async_mode || !data_fail_hold))
      probe_code = HINT_WRONG_SYNC;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dut_rst_q      <= 1'b0;
      data_fail_q    <= 1'b0;
      data_fail_hold <= 1'b0;
      ar_fail_q      <= 1'b0;
      probe_q        <= 1'b0;
      hint_valid     <= 1'b0;
      hint_code      <= HINT_PASS;
      hint_bad       <= 1'b0;
    end else begin
      dut_rst_q  <= dut_rst;
      hint_valid <= 1'b0;
      if (!dut_rst) data_fail_q <= !tb_match;
      if (rst_rise) begin
        probe_q        <= 1'b1;
        ar_fail_q      <= !tb_match;
        data_fail_hold <= data_fail_q;
      end else if (probe_q) begin
        probe_q    <= 1'b0;
        hint_valid <= 1'b1;
        hint_code  <= probe_code;
        if (probe_code != HINT_PASS) hint_bad <= 1'b1;
      end
    end
  end

  assign all_pass = (tot_fail == '0) && !overflow && !hint_bad;

endmodule

// File: tb/tb_tb_match_monitor.sv
// Directed bench for tb_match_monitor: window scoring, FIFO ordering/overflow,
// reset-probe classification and asynchronous reset.
module tb_tb_match_monitor;

  localparam int CNT_W = 16;
  localparam int ID_W  = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             tb_match, dut_rst, async_mode, win_enable, res_ready;
  logic [ID_W-1:0]  win_id;
  logic             res_valid, hint_valid, overflow, all_pass;
  logic [ID_W-1:0]  res_id;
  logic [CNT_W-1:0] res_samples, res_mismatch, res_first, tot_windows, tot_fail;
  logic [1:0]       hint_code;

  int n_tests = 0;
  int n_fail  = 0;

  tb_match_monitor #(.CNT_W(CNT_W), .ID_W(ID_W), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .tb_match(tb_match), .dut_rst(dut_rst),
    .async_mode(async_mode), .win_enable(win_enable), .win_id(win_id),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_samples(res_samples), .res_mismatch(res_mismatch), .res_first(res_first),
    .hint_valid(hint_valid), .hint_code(hint_code), .tot_windows(tot_windows),
    .tot_fail(tot_fail), .overflow(overflow), .all_pass(all_pass)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ID_W-1:0]  id;
    int               len;
    logic [15:0]      mask;     // bit c set = mismatch on cycle c
    logic [CNT_W-1:0] e_samples;
    logic [CNT_W-1:0] e_mism;
    logic [CNT_W-1:0] e_first;
  } win_vec_t;

  typedef struct {
    logic       async_m;
    logic       df;
    logic       af;
    logic       sf;
    logic [1:0] e_code;
  } probe_vec_t;

  win_vec_t   wv [5];
  probe_vec_t pv [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; win_enable = 1'b0; win_id = '0; tb_match = 1'b1;
    dut_rst = 1'b0; async_mode = 1'b0; res_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic pop_expect(input string name, input logic [ID_W-1:0] id);
    check({name, " valid"}, res_valid, 1'b1);
    check({name, " id"}, res_id, id);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic short_window(input logic [ID_W-1:0] id);
    win_enable = 1'b1; win_id = id; tick();
    win_enable = 1'b0; tick();
  endtask

  initial begin
    int exp_fail;
    logic bad;

    wv[0] = '{8'd3,  5, 16'h0000, 16'd5, 16'd0, 16'hFFFF};
    wv[1] = '{8'd7,  6, 16'h0014, 16'd6, 16'd2, 16'd2};
    wv[2] = '{8'd9,  1, 16'h0001, 16'd1, 16'd1, 16'd0};
    wv[3] = '{8'd5,  4, 16'h000F, 16'd4, 16'd4, 16'd0};
    wv[4] = '{8'd10, 3, 16'h0004, 16'd3, 16'd1, 16'd2};

    pv[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    pv[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
    pv[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd2};
    pv[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd2};
    pv[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1};
    pv[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd1};

    // Reset values
    apply_reset();
    check("rst res_valid", res_valid, 1'b0);
    check("rst hint_valid", hint_valid, 1'b0);
    check("rst hint_code", hint_code, 2'd0);
    check("rst tot_windows", tot_windows, 16'd0);
    check("rst tot_fail", tot_fail, 16'd0);
    check("rst overflow", overflow, 1'b0);
    check("rst all_pass", all_pass, 1'b1);
    check("rst res_first", res_first, 16'd0);

    // Table-driven windows
    exp_fail = 0;
    for (int v = 0; v < 5; v++) begin
      win_enable = 1'b1; win_id = wv[v].id;
      for (int c = 0; c < wv[v].len; c++) begin
        tb_match = !wv[v].mask[c];
        tick();
      end
      check("win open no entry", res_valid, 1'b0);
      win_enable = 1'b0; tb_match = 1'b1;
      tick();
      if (wv[v].e_mism != 0) exp_fail++;
      check("win samples", res_samples, wv[v].e_samples);
      check("win mismatch", res_mismatch, wv[v].e_mism);
      check("win first", res_first, wv[v].e_first);
      check("win tot_windows", tot_windows, 32'(v + 1));
      check("win tot_fail", tot_fail, 32'(exp_fail));
      pop_expect("win pop", wv[v].id);
      check("win drained", res_valid, 1'b0);
    end
    check("win all_pass", all_pass, 1'b0);

    // Id change with enable held: back-to-back windows
    win_enable = 1'b1; win_id = 8'd1; tick(); tick();
    win_id = 8'd2; tick();
    check("idchg first close", res_valid, 1'b1);
    tick();
    win_enable = 1'b0; tick();
    check("idchg samples1", res_samples, 16'd2);
    check("idchg first1", res_first, 16'hFFFF);
    pop_expect("idchg pop1", 8'd1);
    check("idchg samples2", res_samples, 16'd2);
    check("idchg mism2", res_mismatch, 16'd0);
    pop_expect("idchg pop2", 8'd2);
    check("idchg tot_windows", tot_windows, 16'd7);

    // Overflow with consumer stalled
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      short_window(ID_W'(11 + k));
      if (k == 3) begin
        check("ovf not yet", overflow, 1'b0);
        check("ovf all_pass before", all_pass, 1'b1);
      end
    end
    check("ovf overflow", overflow, 1'b1);
    check("ovf all_pass", all_pass, 1'b0);
    check("ovf tot_windows", tot_windows, 16'd5);
    for (int k = 0; k < 4; k++) pop_expect("ovf pop", ID_W'(11 + k));
    check("ovf drained", res_valid, 1'b0);
    check("ovf sticky", overflow, 1'b1);

    // Push and pop on the same edge while full
    apply_reset();
    for (int k = 0; k < 4; k++) short_window(ID_W'(21 + k));
    win_enable = 1'b1; win_id = 8'd25; tick();
    win_enable = 1'b0; res_ready = 1'b1; tick();
    res_ready = 1'b0;
    check("full pushpop overflow", overflow, 1'b0);
    for (int k = 0; k < 4; k++) pop_expect("full pushpop pop", ID_W'(22 + k));
    check("full pushpop drained", res_valid, 1'b0);

    // Reset probe vectors; odd entries drop dut_rst before the srfail edge
    apply_reset();
    bad = 1'b0;
    for (int v = 0; v < 6; v++) begin
      async_mode = pv[v].async_m;
      dut_rst = 1'b0; tb_match = !pv[v].df; tick();
      dut_rst = 1'b1; tb_match = !pv[v].af; tick();
      check("probe early", hint_valid, 1'b0);
      dut_rst = (v % 2 == 1) ? 1'b0 : 1'b1;
      tb_match = !pv[v].sf; tick();
      check("probe hint_valid", hint_valid, 1'b1);
      check("probe hint_code", hint_code, pv[v].e_code);
      dut_rst = 1'b0; tb_match = 1'b1; tick();
      check("probe pulse end", hint_valid, 1'b0);
      if (pv[v].e_code != 2'd0) bad = 1'b1;
      check("probe all_pass", all_pass, !bad);
    end

    // Asynchronous reset mid-window
    apply_reset();
    win_enable = 1'b1; win_id = 8'd6; tick(); tick();
    win_id = 8'd4; tb_match = 1'b0; tick(); tick(); tick();
    check("arst pre valid", res_valid, 1'b1);
    check("arst pre tot", tot_windows, 16'd1);
    #3 rst = 1'b1;
    #1;
    check("arst res_valid", res_valid, 1'b0);
    check("arst res_id", res_id, 8'd0);
    check("arst tot_windows", tot_windows, 16'd0);
    check("arst all_pass", all_pass, 1'b1);
    #2 rst = 1'b0; tb_match = 1'b1;
    tick(); tick();
    win_enable = 1'b0; tick();
    check("arst new samples", res_samples, 16'd2);
    check("arst new mismatch", res_mismatch, 16'd0);
    pop_expect("arst pop", 8'd4);
    check("arst only entry", res_valid, 1'b0);
    check("arst tot after", tot_windows, 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
